// File: rtl/mest_pro_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for mest_pro_decode_stage.
// The master side is the environment (fetch and execute); the slave side is the stage.
interface mest_pro_decode_stage_if #(
  parameter int unsigned OPCODE_W = 8,
  parameter int unsigned K_W      = 8,
  parameter int unsigned OPA_W    = 8,
  parameter int unsigned OPB_W    = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned PC_W     = 16,
  parameter int unsigned CNT_W    = 16
);
  localparam int unsigned INSTR_W = OPCODE_W + K_W + OPA_W + OPB_W;

  // Fetch side
  logic               i_valid;
  logic               o_ready;
  logic [INSTR_W-1:0] i_instr;
  logic [PC_W-1:0]    i_pc;

  // Execute side
  logic                o_valid;
  logic                i_ready;
  logic [OPCODE_W-1:0] o_op_code;
  logic [DATA_W-1:0]   o_const_k;
  logic [OPA_W-1:0]    o_operand_a;
  logic [OPB_W-1:0]    o_operand_b;
  logic [PC_W-1:0]     o_pc;
  logic                o_illegal;
  logic [CNT_W-1:0]    o_decode_count;

  modport master (
    output i_valid, i_instr, i_pc, i_ready,
    input  o_ready, o_valid, o_op_code, o_const_k, o_operand_a, o_operand_b, o_pc,
           o_illegal, o_decode_count
  );

  modport slave (
    input  i_valid, i_instr, i_pc, i_ready,
    output o_ready, o_valid, o_op_code, o_const_k, o_operand_a, o_operand_b, o_pc,
           o_illegal, o_decode_count
  );
endinterface

// File: rtl/mest_pro_decode_stage.sv
// MESTPro instruction decode stage: decodes on the input side and stores results in a
// 2-entry skid buffer (head + skid) so full throughput survives execute backpressure.
module mest_pro_decode_stage #(
  parameter int unsigned OPCODE_W = 8,
  parameter int unsigned K_W      = 8,
  parameter int unsigned OPA_W    = 8,
  parameter int unsigned OPB_W    = 8,
  parameter int unsigned DATA_W   = 16,
  parameter bit          K_SEXT   = 1'b1,
  parameter logic [OPCODE_W-1:0] MAX_OPCODE = 'h3F,
  parameter int unsigned PC_W     = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_flush,
  mest_pro_decode_stage_if.slave bus
);
  localparam int unsigned INSTR_W = OPCODE_W + K_W + OPA_W + OPB_W;

  typedef struct packed {
    logic [OPCODE_W-1:0] op_code;
    logic [DATA_W-1:0]   const_k;
    logic [OPA_W-1:0]    operand_a;
    logic [OPB_W-1:0]    operand_b;
    logic [PC_W-1:0]     pc;
    logic                illegal;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  entry_t           in_entry;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             take;
  logic [K_W-1:0]   k_field;
  logic [DATA_W-1:0] k_ext;

  assign k_field = bus.i_instr[OPA_W+OPB_W +: K_W];

  // Zero-width replication is illegal, so the pass-through case is split out.
  if (DATA_W == K_W) begin : g_k_pass
    assign k_ext = k_field;
  end else begin : g_k_ext
    assign k_ext = {{(DATA_W-K_W){K_SEXT & k_field[K_W-1]}}, k_field};
  end

  // Decode the incoming word so only registers sit in front of the outputs.
  always_comb begin
    in_entry           = '0;
    in_entry.op_code   = bus.i_instr[INSTR_W-1 -: OPCODE_W];
    in_entry.const_k   = k_ext;
    in_entry.operand_a = bus.i_instr[OPB_W +: OPA_W];
    in_entry.operand_b = bus.i_instr[OPB_W-1:0];
    in_entry.pc        = bus.i_pc;
    in_entry.illegal   = (bus.i_instr[INSTR_W-1 -: OPCODE_W] > MAX_OPCODE);
  end

  assign accept = bus.i_valid & bus.o_ready;
  assign take   = bus.o_valid & bus.i_ready;

  // Buffer occupancy FSM, data movement and decode counter; flush overrides everything.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    if (i_flush) begin
      state_d = StEmpty;
    end else begin
      if (take) begin
        cnt_d = cnt_q + 1'b1;
      end
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            head_d  = in_entry;
          end
        end
        StOne: begin
          if (accept && take) begin
            head_d = in_entry;
          end else if (accept) begin
            state_d = StTwo;
            skid_d  = in_entry;
          end else if (take) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (take) begin
            state_d = StOne;
            head_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // State, buffer and counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StEmpty;
      head_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_valid        = (state_q != StEmpty);
  assign bus.o_ready        = (state_q != StTwo);
  assign bus.o_op_code      = head_q.op_code;
  assign bus.o_const_k      = head_q.const_k;
  assign bus.o_operand_a    = head_q.operand_a;
  assign bus.o_operand_b    = head_q.operand_b;
  assign bus.o_pc           = head_q.pc;
  assign bus.o_illegal      = head_q.illegal;
  assign bus.o_decode_count = cnt_q;

endmodule

// File: tb/tb_mest_pro_decode_stage.sv
// Bench for mest_pro_decode_stage: two instances (sign-extending/16-bit counter and
// zero-extending/4-bit counter) driven identically and compared against a queue model.
module tb_mest_pro_decode_stage;
  logic clk;
  logic rst_n;
  logic flush;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [15:0] pc;
  } item_t;

  item_t       exp_q[$];
  int unsigned takes = 0;

  mest_pro_decode_stage_if bus_main ();
  mest_pro_decode_stage_if #(.CNT_W(4)) bus_alt ();

  mest_pro_decode_stage dut_main (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .bus     (bus_main)
  );

  mest_pro_decode_stage #(.K_SEXT(1'b0), .CNT_W(4)) dut_alt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .bus     (bus_alt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [15:0] pc,
                       input logic rdy, input logic fl);
    bus_main.i_valid = v;  bus_main.i_instr = instr; bus_main.i_pc = pc; bus_main.i_ready = rdy;
    bus_alt.i_valid  = v;  bus_alt.i_instr  = instr; bus_alt.i_pc  = pc; bus_alt.i_ready  = rdy;
    flush = fl;
  endtask

  // Expected values computed from the instruction word with plain arithmetic.
  task automatic check_outputs();
    int unsigned op, k, a, b, k_s;
    chk("valid",     bus_main.o_valid, exp_q.size() != 0);
    chk("ready",     bus_main.o_ready, exp_q.size() < 2);
    chk("valid_alt", bus_alt.o_valid,  exp_q.size() != 0);
    chk("ready_alt", bus_alt.o_ready,  exp_q.size() < 2);
    chk("count",     bus_main.o_decode_count, takes % 65536);
    chk("count_alt", bus_alt.o_decode_count,  takes % 16);
    if (exp_q.size() != 0) begin
      op  = exp_q[0].instr / 32'h0100_0000;
      k   = (exp_q[0].instr / 32'h0001_0000) % 256;
      a   = (exp_q[0].instr / 256) % 256;
      b   = exp_q[0].instr % 256;
      k_s = (k >= 128) ? k + 32'hFF00 : k;
      chk("op_code",   bus_main.o_op_code,   op);
      chk("const_k",   bus_main.o_const_k,   k_s);
      chk("const_k_z", bus_alt.o_const_k,    k);
      chk("operand_a", bus_main.o_operand_a, a);
      chk("operand_b", bus_main.o_operand_b, b);
      chk("pc",        bus_main.o_pc,        exp_q[0].pc);
      chk("illegal",   bus_main.o_illegal,   op > 63);
      chk("op_alt",    bus_alt.o_op_code,    op);
    end
  endtask

  // One clock: drive just after the rising edge, check on the falling edge, update model.
  task automatic cycle(input logic v, input logic [31:0] instr, input logic [15:0] pc,
                       input logic rdy, input logic fl);
    bit acc, tk;
    drive(v, instr, pc, rdy, fl);
    @(negedge clk);
    check_outputs();
    acc = v && (exp_q.size() < 2);
    tk  = rdy && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (tk) begin
        void'(exp_q.pop_front());
        takes++;
      end
      if (acc) exp_q.push_back('{instr: instr, pc: pc});
    end
  endtask

  task automatic check_reset_values();
    chk("rst_valid",  bus_main.o_valid, 1'b0);
    chk("rst_ready",  bus_main.o_ready, 1'b1);
    chk("rst_op",     bus_main.o_op_code, 0);
    chk("rst_k",      bus_main.o_const_k, 0);
    chk("rst_a",      bus_main.o_operand_a, 0);
    chk("rst_b",      bus_main.o_operand_b, 0);
    chk("rst_pc",     bus_main.o_pc, 0);
    chk("rst_ill",    bus_main.o_illegal, 1'b0);
    chk("rst_cnt",    bus_main.o_decode_count, 0);
    chk("rst_valid2", bus_alt.o_valid, 1'b0);
    chk("rst_cnt2",   bus_alt.o_decode_count, 0);
  endtask

  // Assert reset asynchronously (off any clock edge) and check outputs before any edge.
  task automatic do_reset();
    drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check_reset_values();
    exp_q.delete();
    takes = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned cnt_before;
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    #1;
    do_reset();

    // Directed decode of a negative K.
    cycle(1'b1, 32'h12_F0_34_56, 16'h0100, 1'b1, 1'b0);
    chk("d1_valid", bus_main.o_valid, 1'b1);
    chk("d1_op",    bus_main.o_op_code, 8'h12);
    chk("d1_k",     bus_main.o_const_k, 16'hFFF0);
    chk("d1_kz",    bus_alt.o_const_k, 16'h00F0);
    chk("d1_a",     bus_main.o_operand_a, 8'h34);
    chk("d1_b",     bus_main.o_operand_b, 8'h56);
    chk("d1_pc",    bus_main.o_pc, 16'h0100);
    chk("d1_ill",   bus_main.o_illegal, 1'b0);
    cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    chk("d1_cnt",   bus_main.o_decode_count, 16'd1);
    chk("d1_empty", bus_main.o_valid, 1'b0);

    // Illegal opcode passes through flagged.
    cycle(1'b1, 32'h40_F0_34_56, 16'h0104, 1'b1, 1'b0);
    chk("ill_flag", bus_main.o_illegal, 1'b1);
    chk("ill_op",   bus_main.o_op_code, 8'h40);
    chk("ill_k",    bus_main.o_const_k, 16'hFFF0);
    cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);

    // Eight back-to-back instructions at full rate.
    cnt_before = takes;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, $urandom, 16'(16'h0200 + 4 * i), 1'b1, 1'b0);
      chk("stream_ready", bus_main.o_ready, 1'b1);
      chk("stream_valid", bus_main.o_valid, 1'b1);
    end
    cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    chk("stream_cnt", bus_main.o_decode_count, 16'(cnt_before + 8));

    // Backpressure: i_ready low for 4 cycles during a stream.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, $urandom, 16'(16'h0300 + 4 * i), (i < 2 || i > 5), 1'b0);
    end
    cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    chk("bp_drained", bus_main.o_valid, 1'b0);

    // Flush while full with simultaneous valid and ready.
    cycle(1'b1, 32'h01_02_03_04, 16'h0400, 1'b0, 1'b0);
    cycle(1'b1, 32'h05_06_07_08, 16'h0404, 1'b0, 1'b0);
    chk("two_ready", bus_main.o_ready, 1'b0);
    cnt_before = takes;
    cycle(1'b1, 32'h09_0A_0B_0C, 16'h0408, 1'b1, 1'b1);
    chk("fl_valid", bus_main.o_valid, 1'b0);
    chk("fl_ready", bus_main.o_ready, 1'b1);
    chk("fl_cnt",   bus_main.o_decode_count, 16'(cnt_before));
    cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);

    // Counter wrap on the 4-bit instance: 17 takes.
    do_reset();
    for (int i = 0; i < 17; i++) cycle(1'b1, $urandom, 16'(i), 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    chk("wrap_alt",  bus_alt.o_decode_count, 4'd1);
    chk("wrap_main", bus_main.o_decode_count, 16'd17);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, {8'($urandom_range(0, 80)), 24'($urandom)}, 16'($urandom),
            ($urandom % 3) != 0, ($urandom % 40) == 0);
    end

    // Reset mid-stream with entries buffered.
    cycle(1'b1, 32'h11_22_33_44, 16'h0500, 1'b0, 1'b0);
    cycle(1'b1, 32'h55_66_77_88, 16'h0504, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, $urandom, 16'(i), 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
